quad_grant_sink: RTL
====================

Name: quad_grant_sink

Overview:
- Clocked consumer sitting directly downstream of the four-requester NCL arbiter.
- Receives the arbiter's 1-of-4 winner token (quad rails) and drives the quad completion back to it.
- Runs the four-phase DATA/NULL handshake from a clocked FSM and converts each winner into a grant ID.
- Buffers grant IDs in a small FIFO for synchronous logic, with valid/ready backpressure that stalls the arbiter.

Parameters:
- DEPTH, 4, grant-ID FIFO entries; power of two, at least 2.
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before a quad value is accepted.
- CNT_W, 16, width of each per-requester grant counter (optional feature only).

Ports:
- clk  in  1  system clock.
- init  in  1  reset; synchronous, active-high.
- quad  in  4  NCL 1-of-4 winner rails; asynchronous to clk.
- quadCOMP  out  1  completion to the arbiter: 0 = request DATA, 1 = request NULL.
- grant_valid  out  1  FIFO head valid.
- grant_id  out  2  FIFO head requester index, 0..3.
- grant_ready  in  1  consumer accepts the head when high together with grant_valid.
- fifo_level  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- err_multi  out  1  sticky flag: more than one rail was seen high.
- grant_cnt  out  4*CNT_W  per-requester counts, requester i at bits [i*CNT_W +: CNT_W]; present only with the optional feature.

Behaviour:
- quad passes through a two-flop synchronizer; the result is quad_s. A stability counter tracks how long quad_s has held its current value.
- quad_s is "stable" when it has been identical for STABLE_CYCLES consecutive clocks.
- Reset (init=1 on a clock edge):
  - State = WAIT_NULL, quadCOMP=1.
  - FIFO is emptied: grant_valid=0, grant_id=0, fifo_level=0.
  - err_multi=0; counters=0; synchronizer and stability counter are cleared.
  - Reset asserted mid-handshake discards any unpushed token. The arbiter is then held requesting NULL until quad returns to 0.
- FSM states:
  - WAIT_NULL: quadCOMP=1. When stable quad_s==0, go to WAIT_DATA.
  - WAIT_DATA: quadCOMP=0.
    - Stable quad_s with exactly one bit set, and FIFO not full: push that bit's index and go to WAIT_NULL. quadCOMP rises on the same edge as the push.
    - Same condition, FIFO full: go to HOLD.
    - Stable quad_s with two or more bits set: set err_multi, push nothing, go to WAIT_NULL. This forces NULL so the arbiter can recover.
    - quad_s==0 or not yet stable: remain in WAIT_DATA.
  - HOLD: quadCOMP=0, so the arbiter stays stalled in DATA.
    - When the FIFO is not full, push the held index and go to WAIT_NULL.
    - A pop in the same cycle counts as not full.
    - The index is captured on entry to HOLD; quad_s is not re-sampled while in HOLD.
- Exactly one push per DATA wavefront. No push can occur until quad_s has returned to all-zero, because a push always leads to WAIT_NULL.
- FIFO:
  - Pop occurs when grant_valid && grant_ready.
  - Simultaneous push and pop when full is legal; the level is unchanged.
  - Simultaneous push and pop when empty: the pushed entry appears on the next cycle.
  - grant_id and grant_valid are registered; an empty-FIFO push is visible one cycle after the push edge.
  - Pointers wrap modulo DEPTH.
- Latency, empty FIFO, STABLE_CYCLES=2: rail high before edge 0 gives quad_s valid after edge 1, push at edge 2, grant_valid=1 after edge 3.
- err_multi clears only on init.

Optional Feature:
- Macro: QUAD_GRANT_COUNT_EN.
- Defined:
  - The grant_cnt port exists.
  - The counter for requester i increments on each push of index i.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - A push from HOLD is counted when it is pushed.
- Undefined: no grant_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package quad_grant_pkg:
  - State enum {WAIT_NULL, WAIT_DATA, HOLD}.
  - Constant NUM_REQ=4.
  - Grant-ID typedef logic [1:0].
  - One-hot-to-index function and a popcount-greater-than-one check.
- One sub-module: quad_grant_fifo, a synchronous DEPTH x 2-bit FIFO with push/pop/level, instantiated once.
- The synchronizer and FSM stay in the top level.

Test Plan:
1. Reset sequencing: init held 3 cycles with quad=0000, then released → quadCOMP=1 until 2 stable zero samples, then quadCOMP=0; grant_valid=0; fifo_level=0.
2. Single grant: quad=0100, hold until quadCOMP=1, then quad=0000 → grant_valid=1 and grant_id=2 after the stated 3-edge latency; one entry only; quadCOMP returns to 0.
3. Backpressure: DEPTH=4, grant_ready=0, grants for IDs 0,1,2,3,1 → fifth grant leaves the FSM in HOLD with quadCOMP=0. One pop → ID 1 is pushed, quadCOMP=1, and a drain order of 0,1,2,3,1.
4. Glitch rejection: quad=0001 for 1 cycle then 0000 → no push, quadCOMP stays 0, no count change.
5. Multi-rail error: quad=0011 stable → err_multi=1, no push, quadCOMP=1. After quad=0000, the next legal grant with quad=1000 pushes ID 3 and err_multi stays 1.
6. Mid-operation reset with QUAD_GRANT_COUNT_EN defined: 3 grants of ID 0 counted (grant_cnt[0]=3), then init during HOLD → FIFO empty, counters 0, quadCOMP=1. Separately, CNT_W=2 with 5 grants of ID 0 → count saturates at 3.

Source files
------------

// File: rtl/quad_grant_pkg.sv
// Shared types and helpers for the quad grant sink: FSM state encoding,
// grant-ID type, and rail-decoding functions.
package quad_grant_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef logic [1:0] grant_id_t;

  typedef enum logic [1:0] {
    WAIT_NULL = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2
  } state_e;

  // Index of the set rail; only meaningful when exactly one rail is high.
  function automatic grant_id_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    grant_id_t idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = grant_id_t'(i);
    end
    return idx;
  endfunction

  // True when two or more rails are high.
  function automatic logic multi_hot(input logic [NUM_REQ-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      n += 32'(v[i]);
    end
    return (n > 1);
  endfunction

endpackage

// File: rtl/quad_grant_fifo.sv
// Synchronous DEPTH x 2-bit grant-ID FIFO with a registered head.
// Storage plus the head register together hold at most DEPTH entries.
module quad_grant_fifo
  import quad_grant_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     push_i,
  input  grant_id_t                push_id_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output grant_id_t                id_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  grant_id_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              valid_q;
  grant_id_t         id_q;
  logic [LW-1:0]     mem_cnt;
  logic              refill;

  // Head reloads from storage only with entries already stored, so a push
  // into an empty FIFO becomes visible one cycle after the push edge.
  always_comb begin
    mem_cnt = level_q - LW'(valid_q);
    refill  = (mem_cnt != '0) && (!valid_q || pop_i);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_id_i;
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (refill) begin
        id_q     <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
        valid_q  <= 1'b1;
      end else if (pop_i) begin
        valid_q  <= 1'b0;
      end
      level_q <= level_q + LW'(push_i) - LW'(pop_i);
    end
  end

  assign valid_o = valid_q;
  assign id_o    = id_q;
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/quad_grant_sink.sv
// Clocked consumer for the four-requester NCL arbiter: synchronizes the
// 1-of-4 winner rails, runs the DATA/NULL handshake, and queues grant IDs.
// Optional per-requester grant counters: define QUAD_GRANT_COUNT_EN.
module quad_grant_sink
  import quad_grant_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       init,
  input  logic [3:0]                 quad,
  output logic                       quadCOMP,
  output logic                       grant_valid,
  output logic [1:0]                 grant_id,
  input  logic                       grant_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_multi
`ifdef QUAD_GRANT_COUNT_EN
  ,
  output logic [4*CNT_W-1:0]         grant_cnt
`endif
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < 1) ||
      (STABLE_CYCLES < 1)) begin : g_bad_params
    $error("quad_grant_sink: illegal parameter set");
  end

  logic [3:0]    meta_q;
  logic [3:0]    sync_q;
  logic [SW-1:0] stab_q;
  state_e        state_q, state_d;
  grant_id_t     hold_q, hold_d;
  logic          err_q, err_d;
  logic          stable;
  logic          pop;
  logic          push;
  grant_id_t     push_id;
  logic          fifo_full;
  logic          not_full;

  // Two-flop synchronizer and run-length of the synchronized value.
  always_ff @(posedge clk) begin
    if (init) begin
      meta_q <= '0;
      sync_q <= '0;
      stab_q <= '0;
    end else begin
      meta_q <= quad;
      sync_q <= meta_q;
      if (meta_q != sync_q) stab_q <= SW'(1);
      else if (stab_q != SW'(STABLE_CYCLES)) stab_q <= stab_q + 1'b1;
    end
  end

  // The incoming sample (meta_q) counts toward the run, so a value is
  // accepted on the same edge that completes STABLE_CYCLES matching samples.
  always_comb begin
    stable   = (meta_q == sync_q) && (stab_q >= SW'(STABLE_CYCLES - 1));
    pop      = grant_valid && grant_ready;
    not_full = !fifo_full || pop;
  end

  // Handshake FSM next-state, push decision and error capture.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    err_d   = err_q;
    push    = 1'b0;
    push_id = hold_q;
    unique case (state_q)
      WAIT_NULL: begin
        if (stable && (sync_q == '0)) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (stable && (sync_q != '0)) begin
          if (multi_hot(sync_q)) begin
            err_d   = 1'b1;
            state_d = WAIT_NULL;
          end else if (not_full) begin
            push    = 1'b1;
            push_id = onehot_to_idx(sync_q);
            state_d = WAIT_NULL;
          end else begin
            hold_d  = onehot_to_idx(sync_q);
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (not_full) begin
          push    = 1'b1;
          push_id = hold_q;
          state_d = WAIT_NULL;
        end
      end
      default: state_d = WAIT_NULL;
    endcase
  end

  // FSM state, held index and sticky error flag.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= WAIT_NULL;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign quadCOMP  = (state_q == WAIT_NULL);
  assign err_multi = err_q;

  quad_grant_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .init      (init),
    .push_i    (push),
    .push_id_i (push_id),
    .pop_i     (pop),
    .valid_o   (grant_valid),
    .id_o      (grant_id),
    .level_o   (fifo_level),
    .full_o    (fifo_full)
  );

`ifdef QUAD_GRANT_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  // Saturating per-requester push counters.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (push && (cnt_q[push_id] != '1)) begin
      cnt_q[push_id] <= cnt_q[push_id] + 1'b1;
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule
